// File: rtl/video_timing_pkg.sv
// video_timing_pkg
//   Shared video timing helpers for the scanout path and the upstream drawing
//   blocks: line/frame total and sync-window arithmetic, the per-pixel flag
//   bundle carried down the scanout delay line, and RGB332 -> RGB888 expansion.
package video_timing_pkg;

  // Flags that travel with each pixel from the counter stage to the outputs.
  typedef struct packed {
    logic de;
    logic hsync;
    logic vsync;
    logic frame_start;
    logic busy;
  } scan_flags_t;

  // Total length of a line (in pixels) or of a frame (in lines).
  function automatic int line_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // First count inside the sync pulse.
  function automatic int sync_start(input int active, input int fp);
    return active + fp;
  endfunction

  // First count after the sync pulse.
  function automatic int sync_end(input int active, input int fp, input int sync);
    return active + fp + sync;
  endfunction

  // Bit replication keeps full-scale codes at full scale (0xFF -> 0xFFFFFF)
  // and zero at zero.
  function automatic logic [23:0] rgb332_to_rgb888(input logic [7:0] px);
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
    r = px[7:5];
    g = px[4:2];
    b = px[1:0];
    return {r, r, r[2:1], g, g, g[2:1], b, b, b, b};
  endfunction

endpackage

// File: rtl/video_timing_gen.sv
// video_timing_gen
//   Free-running horizontal/vertical counters and the combinational timing
//   decodes at the counter stage.
// Ports
//   i_clk, i_rst        pixel clock, synchronous active-high reset
//   o_active            pixel lies inside the visible frame
//   o_line_active       current line is a visible line
//   o_line_end          last pixel of a line (h == H_TOTAL-1)
//   o_frame_end         last pixel of a frame
//   o_hsync, o_vsync    sync levels (SYNC_POL is the asserted level)
//   o_frame_start       h == 0 and v == 0
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 480,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_FP         = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 33,
  parameter bit SYNC_POL     = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_active,
  output logic o_line_active,
  output logic o_line_end,
  output logic o_frame_end,
  output logic o_hsync,
  output logic o_vsync,
  output logic o_frame_start
);

  localparam int H_TOTAL = line_total(FRAME_WIDTH, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = line_total(FRAME_HEIGHT, V_FP, V_SYNC, V_BP);
  // One spare bit so the sync-end compare never aliases when a back porch is 0.
  localparam int HW = $clog2(H_TOTAL) + 1;
  localparam int VW = $clog2(V_TOTAL) + 1;

  localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT   = HW'(FRAME_WIDTH);
  localparam logic [HW-1:0] H_SS    = HW'(sync_start(FRAME_WIDTH, H_FP));
  localparam logic [HW-1:0] H_SE    = HW'(sync_end(FRAME_WIDTH, H_FP, H_SYNC));
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT   = VW'(FRAME_HEIGHT);
  localparam logic [VW-1:0] V_SS    = VW'(sync_start(FRAME_HEIGHT, V_FP));
  localparam logic [VW-1:0] V_SE    = VW'(sync_end(FRAME_HEIGHT, V_FP, V_SYNC));

  logic [HW-1:0] r_h_cnt;
  logic [VW-1:0] r_v_cnt;
  logic          w_line_end;
  logic          w_frame_end;

  assign w_line_end  = (r_h_cnt == H_LAST);
  assign w_frame_end = w_line_end && (r_v_cnt == V_LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_line_end) begin
      r_h_cnt <= '0;
      r_v_cnt <= w_frame_end ? '0 : r_v_cnt + VW'(1);
    end else begin
      r_h_cnt <= r_h_cnt + HW'(1);
    end
  end

  assign o_line_end    = w_line_end;
  assign o_frame_end   = w_frame_end;
  assign o_line_active = (r_v_cnt < V_ACT);
  assign o_active      = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
  assign o_hsync       = (r_h_cnt >= H_SS && r_h_cnt < H_SE) ? SYNC_POL : !SYNC_POL;
  assign o_vsync       = (r_v_cnt >= V_SS && r_v_cnt < V_SE) ? SYNC_POL : !SYNC_POL;
  assign o_frame_start = (r_h_cnt == '0) && (r_v_cnt == '0);

endmodule

// File: rtl/framebuffer_scanout.sv
// framebuffer_scanout
//   Read-side consumer of the framebuffer on the pixel clock. Generates video
//   timing, walks the framebuffer with SFxSF pixel replication, hides the RAM
//   read latency behind a matching delay line and expands RGB332 to RGB888.
// Ports
//   i_clk, i_rst     pixel clock (framebuffer clk_rd), synchronous active-high reset
//   i_fb_busy        framebuffer reset busy; affected pixels are shown black
//   o_en_rd          framebuffer read enable (high on visible pixels)
//   o_addr_rd        framebuffer read address (holds during blanking)
//   i_dout           framebuffer read data, RGB332
//   o_hsync/o_vsync  sync outputs
//   o_de             data enable
//   o_rgb            {R8,G8,B8}
//   o_frame_start    one-cycle pulse with the first de of each frame
module framebuffer_scanout
  import video_timing_pkg::*;
#(
  parameter int FRAME_WIDTH    = 640,
  parameter int FRAME_HEIGHT   = 480,
  parameter int SCALING_FACTOR = 1,
  parameter int ADDR_WIDTH     = 19,
  parameter int DATA_WIDTH     = 8,
  parameter int H_FP           = 16,
  parameter int H_SYNC         = 96,
  parameter int H_BP           = 48,
  parameter int V_FP           = 10,
  parameter int V_SYNC         = 2,
  parameter int V_BP           = 33,
  parameter bit SYNC_POL       = 1'b0,
  parameter int RD_LATENCY     = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_fb_busy,
  output logic                  o_en_rd,
  output logic [ADDR_WIDTH-1:0] o_addr_rd,
  input  logic [DATA_WIDTH-1:0] i_dout,
  output logic                  o_hsync,
  output logic                  o_vsync,
  output logic                  o_de,
  output logic [23:0]           o_rgb,
  output logic                  o_frame_start
);

  if (DATA_WIDTH != 8) begin : g_bad_data_width
    $error("framebuffer_scanout: DATA_WIDTH must be 8 (RGB332)");
  end
  if ((FRAME_WIDTH % SCALING_FACTOR) != 0 || (FRAME_HEIGHT % SCALING_FACTOR) != 0) begin : g_bad_scale
    $error("framebuffer_scanout: SCALING_FACTOR must divide the frame size");
  end
  if (RD_LATENCY < 1 || RD_LATENCY > 2) begin : g_bad_latency
    $error("framebuffer_scanout: RD_LATENCY must be 1 or 2");
  end

  localparam int  COLS      = FRAME_WIDTH / SCALING_FACTOR;
  localparam int  SW        = (SCALING_FACTOR > 1) ? $clog2(SCALING_FACTOR) : 1;
  localparam logic [SW-1:0] SUB_LAST = SW'(SCALING_FACTOR - 1);
  localparam logic SYNC_IDLE = !SYNC_POL;
  localparam scan_flags_t FLAGS_IDLE = '{1'b0, SYNC_IDLE, SYNC_IDLE, 1'b0, 1'b0};

  // ---------------- counter stage ----------------
  logic w_active, w_line_active, w_line_end, w_frame_end;
  logic w_hsync, w_vsync, w_frame_start;

  video_timing_gen #(
    .FRAME_WIDTH (FRAME_WIDTH),
    .FRAME_HEIGHT(FRAME_HEIGHT),
    .H_FP        (H_FP),
    .H_SYNC      (H_SYNC),
    .H_BP        (H_BP),
    .V_FP        (V_FP),
    .V_SYNC      (V_SYNC),
    .V_BP        (V_BP),
    .SYNC_POL    (SYNC_POL)
  ) u_timing (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .o_active     (w_active),
    .o_line_active(w_line_active),
    .o_line_end   (w_line_end),
    .o_frame_end  (w_frame_end),
    .o_hsync      (w_hsync),
    .o_vsync      (w_vsync),
    .o_frame_start(w_frame_start)
  );

  // Address walk: col/row_base are the address of the pixel at the counter
  // stage, maintained incrementally so no multiplier is needed.
  logic [SW-1:0]         r_col_sub;
  logic [SW-1:0]         r_line_sub;
  logic [ADDR_WIDTH-1:0] r_col;
  logic [ADDR_WIDTH-1:0] r_row_base;
  logic [ADDR_WIDTH-1:0] w_pix_addr;

  assign w_pix_addr = r_row_base + r_col;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_col_sub  <= '0;
      r_col      <= '0;
      r_line_sub <= '0;
      r_row_base <= '0;
    end else begin
      if (w_line_end) begin
        r_col_sub <= '0;
        r_col     <= '0;
      end else if (w_active) begin
        if (r_col_sub == SUB_LAST) begin
          r_col_sub <= '0;
          r_col     <= r_col + ADDR_WIDTH'(1);
        end else begin
          r_col_sub <= r_col_sub + SW'(1);
        end
      end

      if (w_frame_end) begin
        r_line_sub <= '0;
        r_row_base <= '0;
      end else if (w_line_end && w_line_active) begin
        if (r_line_sub == SUB_LAST) begin
          r_line_sub <= '0;
          r_row_base <= r_row_base + ADDR_WIDTH'(COLS);
        end else begin
          r_line_sub <= r_line_sub + SW'(1);
        end
      end
    end
  end

  // ---------------- read request stage ----------------
  logic                  r_en_rd;
  logic [ADDR_WIDTH-1:0] r_addr_rd;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_en_rd   <= 1'b0;
      r_addr_rd <= '0;
    end else begin
      r_en_rd <= w_active;
      if (w_active) begin
        r_addr_rd <= w_pix_addr;
      end
    end
  end

  assign o_en_rd   = r_en_rd;
  assign o_addr_rd = r_addr_rd;

  // ---------------- latency-matching delay line ----------------
  // Stage 0 lines up with the address register, stage RD_LATENCY with dout.
  scan_flags_t w_flags;

  assign w_flags = '{w_active, w_hsync, w_vsync, w_frame_start, i_fb_busy};

  genvar gi;
  for (gi = 0; gi <= RD_LATENCY; gi++) begin : g_dly
    scan_flags_t r_stage;
    scan_flags_t w_stage_in;
    if (gi == 0) begin : g_head
      assign w_stage_in = w_flags;
    end else begin : g_tail
      assign w_stage_in = g_dly[gi-1].r_stage;
    end
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_stage <= FLAGS_IDLE;
      end else begin
        r_stage <= w_stage_in;
      end
    end
  end

  // ---------------- output stage ----------------
  scan_flags_t w_last;
  logic        r_de, r_hsync, r_vsync, r_frame_start;
  logic [23:0] r_rgb;

  assign w_last = g_dly[RD_LATENCY].r_stage;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_de          <= 1'b0;
      r_hsync       <= SYNC_IDLE;
      r_vsync       <= SYNC_IDLE;
      r_frame_start <= 1'b0;
      r_rgb         <= '0;
    end else begin
      r_de          <= w_last.de;
      r_hsync       <= w_last.hsync;
      r_vsync       <= w_last.vsync;
      r_frame_start <= w_last.frame_start;
      r_rgb         <= (w_last.de && !w_last.busy) ? rgb332_to_rgb888(i_dout) : 24'h0;
    end
  end

  assign o_de          = r_de;
  assign o_hsync       = r_hsync;
  assign o_vsync       = r_vsync;
  assign o_frame_start = r_frame_start;
  assign o_rgb         = r_rgb;

endmodule

// File: tb/tb_framebuffer_scanout.sv
// tb_framebuffer_scanout
//   Two instances on a reduced frame: dut 0 at SF=1, RD_LATENCY=1, active-low
//   sync; dut 1 at SF=2, RD_LATENCY=2, active-high sync. Each has its own RAM
//   model over a shared content array. Expectations come from the pixel index
//   since reset release, derived arithmetically from the timing rules.
module tb_framebuffer_scanout;

  localparam int FW = 32, FH = 16;
  localparam int HFP = 4, HS = 8, HBP = 6;
  localparam int VFP = 2, VS = 2, VBP = 3;
  localparam int HT = FW + HFP + HS + HBP;
  localparam int VT = FH + VFP + VS + VBP;
  localparam int FRAME = HT * VT;

  function automatic int sf_of(input int d);  return (d == 0) ? 1 : 2; endfunction
  function automatic int lat_of(input int d); return (d == 0) ? 1 : 2; endfunction
  function automatic bit pol_of(input int d); return (d == 0) ? 1'b0 : 1'b1; endfunction

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy = 1'b0;
  logic        en_w   [2];
  logic [18:0] addr_w [2];
  logic [7:0]  dout_w [2];
  logic        hs_w   [2];
  logic        vs_w   [2];
  logic        de_w   [2];
  logic        fs_w   [2];
  logic [23:0] rgb_w  [2];
  logic [7:0]  mem [0:511];
  logic [7:0]  ram_b1;

  always #5 clk = ~clk;

  framebuffer_scanout #(
    .FRAME_WIDTH(FW), .FRAME_HEIGHT(FH), .SCALING_FACTOR(1), .ADDR_WIDTH(19), .DATA_WIDTH(8),
    .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .SYNC_POL(1'b0), .RD_LATENCY(1)
  ) dut_a (
    .i_clk(clk), .i_rst(rst), .i_fb_busy(busy), .o_en_rd(en_w[0]), .o_addr_rd(addr_w[0]),
    .i_dout(dout_w[0]), .o_hsync(hs_w[0]), .o_vsync(vs_w[0]), .o_de(de_w[0]),
    .o_rgb(rgb_w[0]), .o_frame_start(fs_w[0])
  );

  framebuffer_scanout #(
    .FRAME_WIDTH(FW), .FRAME_HEIGHT(FH), .SCALING_FACTOR(2), .ADDR_WIDTH(19), .DATA_WIDTH(8),
    .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .SYNC_POL(1'b1), .RD_LATENCY(2)
  ) dut_b (
    .i_clk(clk), .i_rst(rst), .i_fb_busy(busy), .o_en_rd(en_w[1]), .o_addr_rd(addr_w[1]),
    .i_dout(dout_w[1]), .o_hsync(hs_w[1]), .o_vsync(vs_w[1]), .o_de(de_w[1]),
    .o_rgb(rgb_w[1]), .o_frame_start(fs_w[1])
  );

  // Framebuffer read ports: latency 1 for dut 0, latency 2 for dut 1.
  always @(posedge clk) begin
    dout_w[0] <= mem[addr_w[0][8:0]];
    ram_b1    <= mem[addr_w[1][8:0]];
    dout_w[1] <= ram_b1;
  end

  int errors = 0;
  int checks = 0;
  int k = 0;
  int last_addr [2];
  bit busy_en = 1'b0;
  bit busy_hist [0:4095];
  logic        e_de [2], e_hs [2], e_vs [2], e_fs [2], e_en [2];
  logic [23:0] e_rgb [2];
  logic [18:0] e_addr [2];

  // ---------------- reference model ----------------
  function automatic int pix_addr(input int sf, input int h, input int v);
    return (v / sf) * (FW / sf) + h / sf;
  endfunction

  // Each channel is scaled towards full range: 3-bit -> n*36 + n/2, 2-bit -> n*85.
  function automatic logic [23:0] expand(input logic [7:0] b);
    int r, g, bl;
    r  = int'(b[7:5]);
    g  = int'(b[4:2]);
    bl = int'(b[1:0]);
    return 24'((r * 36 + r / 2) * 65536 + (g * 36 + g / 2) * 256 + bl * 85);
  endfunction

  function automatic logic [7:0] pat_byte(input int i);
    case (i % 4)
      0: return 8'hE0;
      1: return 8'h1C;
      2: return 8'h03;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [23:0] pat_rgb(input int i);
    case (i % 4)
      0: return 24'hFF0000;
      1: return 24'h00FF00;
      2: return 24'h0000FF;
      default: return 24'hFFFFFF;
    endcase
  endfunction

  task automatic model();
    for (int d = 0; d < 2; d++) begin
      int q, p, h, v;
      bit pol, act;
      pol = pol_of(d);
      q = k - (lat_of(d) + 2);
      if (q < 0) begin
        e_de[d] = 1'b0; e_hs[d] = !pol; e_vs[d] = !pol; e_fs[d] = 1'b0; e_rgb[d] = 24'h0;
      end else begin
        h = q % HT;
        v = (q / HT) % VT;
        act = (h < FW) && (v < FH);
        e_de[d]  = act;
        e_hs[d]  = (h >= FW + HFP && h < FW + HFP + HS) ? pol : !pol;
        e_vs[d]  = (v >= FH + VFP && v < FH + VFP + VS) ? pol : !pol;
        e_fs[d]  = (h == 0) && (v == 0);
        e_rgb[d] = (act && !busy_hist[q]) ? expand(mem[pix_addr(sf_of(d), h, v)]) : 24'h0;
      end
      if (k == 0) begin
        e_en[d] = 1'b0;
      end else begin
        p = k - 1;
        h = p % HT;
        v = (p / HT) % VT;
        act = (h < FW) && (v < FH);
        e_en[d] = act;
        if (act) last_addr[d] = pix_addr(sf_of(d), h, v);
      end
      e_addr[d] = 19'(last_addr[d]);
    end
  endtask

  task automatic drive_busy();
    int v;
    v = (k / HT) % VT;
    busy = busy_en && (v == 5 || v == 6);
    if (k < 4096) busy_hist[k] = busy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    k++;
    drive_busy();
    model();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    k = 0;
    last_addr[0] = 0;
    last_addr[1] = 0;
    drive_busy();
    model();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        checks++;
        if ({de_w[d], fs_w[d], en_w[d], hs_w[d], vs_w[d]} !== {3'b000, !pol_of(d), !pol_of(d)} ||
            addr_w[d] !== 19'd0 || rgb_w[d] !== 24'h0) begin
          errors++;
          $display("FAIL reset_values dut=%0d cyc=%0d got de/fs/en/hs/vs=%b%b%b%b%b addr=%0d rgb=%h",
                   d, i, de_w[d], fs_w[d], en_w[d], hs_w[d], vs_w[d], addr_w[d], rgb_w[d]);
        end
      end
    end
    rst = 1'b0;
    k = 0;
    last_addr[0] = 0;
    last_addr[1] = 0;
    drive_busy();
    model();
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (k < 3 && de_w[0] !== 1'b0) begin
        errors++;
        $display("FAIL reset_early_de k=%0d got=%b required=0", k, de_w[0]);
      end else if (k == 3 && {de_w[0], fs_w[0]} !== 2'b11) begin
        errors++;
        $display("FAIL reset_first_pixel k=%0d got de/fs=%b%b required=11", k, de_w[0], fs_w[0]);
      end
      for (int d = 0; d < 2; d++) begin
        checks++;
        if ({de_w[d], fs_w[d], hs_w[d], vs_w[d]} !== {e_de[d], e_fs[d], e_hs[d], e_vs[d]}) begin
          errors++;
          $display("FAIL reset_release dut=%0d k=%0d got=%b%b%b%b required=%b%b%b%b", d, k,
                   de_w[d], fs_w[d], hs_w[d], vs_w[d], e_de[d], e_fs[d], e_hs[d], e_vs[d]);
        end
      end
    end
    $display("test_reset done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_timing();
    int de_cnt [2], hs_cnt [2], vs_cnt [2];
    int hs_first, hs_second, vs_start;
    logic prev_hs, prev_vs;
    de_cnt = '{0, 0}; hs_cnt = '{0, 0}; vs_cnt = '{0, 0};
    hs_first = -1; hs_second = -1; vs_start = -1;
    prev_hs = hs_w[0]; prev_vs = vs_w[0];
    for (int i = 0; i < FRAME; i++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if ({de_w[d], fs_w[d], hs_w[d], vs_w[d]} !== {e_de[d], e_fs[d], e_hs[d], e_vs[d]}) begin
          errors++;
          $display("FAIL timing dut=%0d k=%0d got de/fs/hs/vs=%b%b%b%b required=%b%b%b%b", d, k,
                   de_w[d], fs_w[d], hs_w[d], vs_w[d], e_de[d], e_fs[d], e_hs[d], e_vs[d]);
        end
        if (de_w[d] === 1'b1) de_cnt[d]++;
        if (hs_w[d] === pol_of(d)) hs_cnt[d]++;
        if (vs_w[d] === pol_of(d)) vs_cnt[d]++;
      end
      if (hs_w[0] === 1'b0 && prev_hs === 1'b1) begin
        if (hs_first < 0) hs_first = k;
        else if (hs_second < 0) hs_second = k;
      end
      if (vs_w[0] === 1'b0 && prev_vs === 1'b1 && vs_start < 0) vs_start = k;
      prev_hs = hs_w[0];
      prev_vs = vs_w[0];
    end
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (de_cnt[d] != FW * FH) begin
        errors++;
        $display("FAIL de_count dut=%0d got=%0d required=%0d", d, de_cnt[d], FW * FH);
      end
      checks++;
      if (hs_cnt[d] != HS * VT || vs_cnt[d] != VS * HT) begin
        errors++;
        $display("FAIL sync_count dut=%0d got hs=%0d vs=%0d required hs=%0d vs=%0d",
                 d, hs_cnt[d], vs_cnt[d], HS * VT, VS * HT);
      end
    end
    checks++;
    if (hs_second - hs_first != HT || (hs_first - 3) % HT != FW + HFP) begin
      errors++;
      $display("FAIL hsync_place starts=%0d,%0d required period=%0d offset=%0d", hs_first, hs_second, HT, FW + HFP);
    end
    checks++;
    if (vs_start < 3 || (vs_start - 3) % FRAME != (FH + VFP) * HT) begin
      errors++;
      $display("FAIL vsync_place start=%0d required pixel=%0d", vs_start, (FH + VFP) * HT);
    end
    $display("test_timing done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_scaling();
    int max_addr [2];
    max_addr = '{-1, -1};
    do_reset(2);
    for (int i = 0; i < FRAME + 6; i++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (en_w[d] !== e_en[d] || addr_w[d] !== e_addr[d]) begin
          errors++;
          $display("FAIL addr dut=%0d k=%0d got en=%b addr=%0d required en=%b addr=%0d",
                   d, k, en_w[d], addr_w[d], e_en[d], e_addr[d]);
        end
        checks++;
        if (rgb_w[d] !== e_rgb[d]) begin
          errors++;
          $display("FAIL pixel_data dut=%0d k=%0d got=%h required=%h", d, k, rgb_w[d], e_rgb[d]);
        end
        if (en_w[d] === 1'b1 && int'(addr_w[d]) > max_addr[d]) max_addr[d] = int'(addr_w[d]);
      end
      if (k - 1 == HT + FW - 1 || k - 1 == 2 * HT) begin
        checks++;
        if (addr_w[1] !== ((k - 1 == 2 * HT) ? 19'd16 : 19'd15)) begin
          errors++;
          $display("FAIL sf2_row_edge k=%0d got=%0d", k, addr_w[1]);
        end
      end
    end
    checks++;
    if (max_addr[0] != FW * FH - 1 || max_addr[1] != (FW / 2) * (FH / 2) - 1) begin
      errors++;
      $display("FAIL last_addr got=%0d,%0d required=%0d,%0d", max_addr[0], max_addr[1],
               FW * FH - 1, (FW / 2) * (FH / 2) - 1);
    end
    $display("test_scaling done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_colours();
    int q, h, v;
    for (int i = 0; i < 512; i++) mem[i] = pat_byte(i);
    do_reset(2);
    for (int i = 0; i < FRAME + 6; i++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        q = k - (lat_of(d) + 2);
        if (q >= 0 && e_de[d]) begin
          h = q % HT;
          v = (q / HT) % VT;
          checks++;
          if (rgb_w[d] !== pat_rgb(pix_addr(sf_of(d), h, v))) begin
            errors++;
            $display("FAIL colour dut=%0d h=%0d v=%0d got=%h required=%h", d, h, v, rgb_w[d],
                     pat_rgb(pix_addr(sf_of(d), h, v)));
          end
        end
      end
    end
    for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
    $display("test_colours done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_busy();
    int q, v;
    int busy_de [2];
    busy_de = '{0, 0};
    busy_en = 1'b1;
    do_reset(2);
    for (int i = 0; i < FRAME + 6; i++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if ({de_w[d], hs_w[d], vs_w[d]} !== {e_de[d], e_hs[d], e_vs[d]} || rgb_w[d] !== e_rgb[d]) begin
          errors++;
          $display("FAIL busy_pixel dut=%0d k=%0d got de/hs/vs=%b%b%b rgb=%h required=%b%b%b rgb=%h", d, k,
                   de_w[d], hs_w[d], vs_w[d], rgb_w[d], e_de[d], e_hs[d], e_vs[d], e_rgb[d]);
        end
        q = k - (lat_of(d) + 2);
        v = (q >= 0) ? (q / HT) % VT : -1;
        if (v == 5 || v == 6) begin
          if (de_w[d] === 1'b1) busy_de[d]++;
          checks++;
          if (rgb_w[d] !== 24'h0) begin
            errors++;
            $display("FAIL busy_black dut=%0d line=%0d got=%h required=000000", d, v, rgb_w[d]);
          end
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (busy_de[d] != 2 * FW) begin
        errors++;
        $display("FAIL busy_de dut=%0d got=%0d required=%0d", d, busy_de[d], 2 * FW);
      end
    end
    busy_en = 1'b0;
    busy = 1'b0;
    $display("test_busy done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_midframe_reset();
    int first_fs [2], stray_de [2];
    first_fs = '{-1, -1};
    stray_de = '{0, 0};
    do_reset(2);
    while (k < 10 * HT + 20) tick();
    do_reset(1);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({de_w[d], fs_w[d]} !== 2'b00 || rgb_w[d] !== 24'h0 || en_w[d] !== 1'b0) begin
        errors++;
        $display("FAIL midreset_flush dut=%0d got de/fs/en=%b%b%b rgb=%h", d, de_w[d], fs_w[d], en_w[d], rgb_w[d]);
      end
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        if (fs_w[d] === 1'b1 && first_fs[d] < 0) first_fs[d] = k;
        if (de_w[d] === 1'b1 && first_fs[d] < 0) stray_de[d]++;
      end
    end
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (first_fs[d] != lat_of(d) + 2 || stray_de[d] != 0) begin
        errors++;
        $display("FAIL midreset_restart dut=%0d got fs_at=%0d stray_de=%0d required fs_at=%0d stray_de=0",
                 d, first_fs[d], stray_de[d], lat_of(d) + 2);
      end
    end
    $display("test_midframe_reset done: checks=%0d errors=%0d", checks, errors);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
    last_addr[0] = 0;
    last_addr[1] = 0;
    test_reset();
    test_timing();
    test_scaling();
    test_colours();
    test_busy();
    test_midframe_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
